// File: rtl/maze_vga_renderer_pkg.sv
// Shared maze geometry, colour defaults, 640x480@60 timing defaults and the
// tile bit-index helper used by the VGA renderer.
package maze_vga_renderer_pkg;
    localparam int MAZE_W    = 16;
    localparam int MAZE_H    = 16;
    localparam int MAZE_BITS = MAZE_W * MAZE_H;

    localparam logic [7:0] WALL_RGB_DEF   = 8'b000_000_10;
    localparam logic [7:0] PATH_RGB_DEF   = 8'b111_111_11;
    localparam logic [7:0] PLAYER_RGB_DEF = 8'b111_000_00;

    // 640x480@60 Hz timing at a 25 MHz pixel clock
    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    // Bitmap layout: bit [x + 16*y]
    function automatic logic [7:0] tile_idx(input logic [3:0] tx, input logic [3:0] ty);
        return {ty, tx};
    endfunction
endpackage

// File: rtl/maze_vga_renderer_vga_timing.sv
// Raster counters with sync/visible decode. Decoded flags are combinational
// from the counters; the top registers them once so all outputs stay aligned.
module vga_timing #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hs,
    output logic       vs,
    output logic       vis,
    output logic       frame_tick
);
    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_LO   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_HI   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_HI   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);

    // Horizontal counter wraps at line end and steps the vertical counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Sync pulses are active low; visible and frame tick are active high
    always_comb begin
        hs         = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
        vs         = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));
        vis        = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
        frame_tick = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
endmodule

// File: rtl/maze_vga_renderer.sv
// Renders the carver's 16x16 path bitmap plus a player tile. The bitmap is
// snapshotted once per frame at the start of vsync so the picture never tears.
module maze_vga_renderer
    import maze_vga_renderer_pkg::*;
#(
    parameter int         TILE_SHIFT = 4,
    parameter int         X_ORG      = 192,
    parameter int         Y_ORG      = 112,
    parameter logic [7:0] WALL_RGB   = WALL_RGB_DEF,
    parameter logic [7:0] PATH_RGB   = PATH_RGB_DEF,
    parameter logic [7:0] PLAYER_RGB = PLAYER_RGB_DEF,
    parameter int         H_VIS      = H_VIS_DEF,
    parameter int         H_FP       = H_FP_DEF,
    parameter int         H_SYNC     = H_SYNC_DEF,
    parameter int         H_BP       = H_BP_DEF,
    parameter int         V_VIS      = V_VIS_DEF,
    parameter int         V_FP       = V_FP_DEF,
    parameter int         V_SYNC     = V_SYNC_DEF,
    parameter int         V_BP       = V_BP_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MAZE_BITS-1:0] maze_data,
    input  logic                 maze_done,
    input  logic [3:0]           player_x,
    input  logic [3:0]           player_y,
    output logic                 hsync,
    output logic                 vsync,
    output logic [7:0]           rgb,
    output logic                 frame_start
);
    localparam logic [9:0] X_LO   = 10'(X_ORG);
    localparam logic [9:0] X_HI   = 10'(X_ORG + (MAZE_W << TILE_SHIFT));
    localparam logic [9:0] Y_LO   = 10'(Y_ORG);
    localparam logic [9:0] Y_HI   = 10'(Y_ORG + (MAZE_H << TILE_SHIFT));
    // First vsync line: well clear of the visible area
    localparam logic [9:0] SNAP_V = 10'(V_VIS + V_FP);

    logic [9:0]           h_cnt, v_cnt;
    logic                 hs, vs, vis, frame_tick;
    logic [MAZE_BITS-1:0] snap;
    logic [3:0]           tx, ty;
    logic                 in_maze;
    logic [7:0]           pix;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .hs         (hs),
        .vs         (vs),
        .vis        (vis),
        .frame_tick (frame_tick)
    );

    // Latch the bitmap once per frame, and only when the carver says it is stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            snap <= '0;
        else if ((h_cnt == 10'd0) && (v_cnt == SNAP_V) && maze_done)
            snap <= maze_data;
    end

    // Tile lookup and colour priority: player, then path, then wall
    always_comb begin
        in_maze = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
        tx      = 4'((h_cnt - X_LO) >> TILE_SHIFT);
        ty      = 4'((v_cnt - Y_LO) >> TILE_SHIFT);
        pix     = 8'h00;
        if (vis && in_maze) begin
            if ((tx == player_x) && (ty == player_y))
                pix = PLAYER_RGB;
            else if (snap[tile_idx(tx, ty)])
                pix = PATH_RGB;
            else
                pix = WALL_RGB;
        end
    end

    // Single output register stage keeps syncs, colour and frame pulse aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs;
            vsync       <= vs;
            rgb         <= pix;
            frame_start <= frame_tick;
        end
    end
endmodule

// File: tb/tb_maze_vga_renderer.sv
// Directed bench. A shrunk-raster instance (64x47 total, 2 px tiles at (8,4))
// exercises frame-level behaviour quickly; a default-parameter instance checks
// reset and real 640x480 horizontal sync placement.
module tb_maze_vga_renderer;
    localparam int HT    = 64;   // 48 vis + 4 fp + 8 sync + 4 bp
    localparam int VT    = 47;   // 40 vis + 2 fp + 2 sync + 3 bp
    localparam int FRAME = HT * VT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] maze_data = '0;
    logic         maze_done = 1'b0;
    logic [3:0]   player_x = 4'd15, player_y = 4'd15;
    logic         hsync, vsync, frame_start;
    logic [7:0]   rgb;
    logic         d_hsync, d_vsync, d_frame_start;
    logic [7:0]   d_rgb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    maze_vga_renderer #(
        .TILE_SHIFT(1), .X_ORG(8), .Y_ORG(4),
        .H_VIS(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(40), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .maze_data(maze_data), .maze_done(maze_done),
        .player_x(player_x), .player_y(player_y),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
    );

    maze_vga_renderer dut_full (
        .clk(clk), .rst_n(rst_n), .maze_data(maze_data), .maze_done(maze_done),
        .player_x(player_x), .player_y(player_y),
        .hsync(d_hsync), .vsync(d_vsync), .rgb(d_rgb), .frame_start(d_frame_start)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs now show raster position cyc-1 of the small instance
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance to the next time pixel (h,v) is presented on the outputs
    task automatic wait_pix(input int h, input int v);
        do tick(); while (((cyc - 1) % FRAME) != v * HT + h);
    endtask

    int hs_low, vs_low, fs_cnt, hs_first, vs_first, dhs_low, dhs_first, dvs_low;

    initial begin
        #23;
        // Reset values on both instances
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_rgb", rgb, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_full_hsync", d_hsync, 1);
        chk("rst_full_rgb", d_rgb, 0);

        @(negedge clk) rst_n = 1'b1;
        cyc = 0;
        tick();
        chk("first_fs", frame_start, 1);

        // One full frame of sync statistics
        hs_low = 0; vs_low = 0; fs_cnt = 0; hs_first = 0; vs_first = 0;
        dhs_low = 0; dhs_first = 0; dvs_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (!hsync) begin hs_low++; if (hs_first == 0) hs_first = cyc; end
            if (!vsync) begin vs_low++; if (vs_first == 0) vs_first = cyc; end
            if (frame_start) fs_cnt++;
            if (i < 1600 && !d_hsync) begin dhs_low++; if (dhs_first == 0) dhs_first = cyc; end
            if (!d_vsync) dvs_low++;
        end
        chk("hs_low_frame", hs_low, 8 * VT);
        chk("vs_low_frame", vs_low, 2 * HT);
        chk("hs_first_cyc", hs_first, 53);
        chk("vs_first_cyc", vs_first, 42 * HT + 1);
        chk("fs_per_frame", fs_cnt, 1);
        chk("fs_period", frame_start, 1);
        chk("full_hs_low_2lines", dhs_low, 192);
        chk("full_hs_first_cyc", dhs_first, 657);
        chk("full_vs_low_early", dvs_low, 0);

        // Bitmap all path, done high: not visible until after the snapshot
        maze_data = '1; maze_done = 1'b1; player_x = 4'd15; player_y = 4'd15;
        wait_pix(8, 4);  chk("pre_snap_wall", rgb, 8'h02);
        wait_pix(0, 43);
        wait_pix(48, 0); chk("hblank_0", rgb, 8'h00);
        wait_pix(8, 3);  chk("above_maze", rgb, 8'h00);
        wait_pix(7, 4);  chk("left_of_maze", rgb, 8'h00);
        wait_pix(8, 4);  chk("maze_corner_path", rgb, 8'hFF);
        wait_pix(40, 4); chk("right_of_maze", rgb, 8'h00);
        wait_pix(39, 35); chk("player_15_15", rgb, 8'hE0);
        wait_pix(0, 40); chk("vblank_0", rgb, 8'h00);

        // Single path tile (1,1), player at (0,0)
        maze_data = '0; maze_data[17] = 1'b1; player_x = 4'd0; player_y = 4'd0;
        wait_pix(0, 43);
        wait_pix(8, 4);  chk("t00_player_a", rgb, 8'hE0);
        wait_pix(10, 4); chk("t10_wall", rgb, 8'h02);
        wait_pix(9, 5);  chk("t00_player_b", rgb, 8'hE0);
        wait_pix(8, 6);  chk("t01_wall", rgb, 8'h02);
        wait_pix(10, 6); chk("t11_path_a", rgb, 8'hFF);
        wait_pix(12, 6); chk("t21_wall", rgb, 8'h02);
        wait_pix(11, 7); chk("t11_path_b", rgb, 8'hFF);
        // Player moves mid-frame: effective for later pixels of this frame
        player_x = 4'd15; player_y = 4'd15;
        wait_pix(38, 34); chk("player_moved_mid", rgb, 8'hE0);

        // Done low: new data ignored across a boundary
        maze_done = 1'b0; maze_data = '1;
        wait_pix(0, 43);
        wait_pix(10, 6); chk("hold_path", rgb, 8'hFF);
        wait_pix(12, 6); chk("hold_wall", rgb, 8'h02);
        wait_pix(0, 30); maze_done = 1'b1;
        wait_pix(12, 32); chk("done_mid_frame", rgb, 8'h02);
        wait_pix(0, 43);
        wait_pix(12, 6); chk("done_next_frame", rgb, 8'hFF);

        // Reset mid-frame
        wait_pix(20, 20); chk("pre_rst_rgb", rgb, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("midrst_rgb", rgb, 0);
        chk("midrst_hsync", hsync, 1);
        chk("midrst_vsync", vsync, 1);
        chk("midrst_fs", frame_start, 0);
        #40;
        @(negedge clk) rst_n = 1'b1;
        cyc = 0;
        tick(); chk("post_rst_fs", frame_start, 1);
        tick(); chk("post_rst_fs_end", frame_start, 0);
        wait_pix(12, 6);  chk("post_rst_snap_wall", rgb, 8'h02);
        wait_pix(38, 34); chk("post_rst_player", rgb, 8'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
